// File: rtl/rf_dump_ctrl.sv
// rf_dump_ctrl: waits for the CPU to reach HALT_PC (or for the run-cycle
// budget to run out), then freezes the CPU and streams a dump frame out over
// a valid/ready port. A normal frame carries the captured pc, the captured
// instr and rf[0..31]. A timeout frame carries a DEAD marker and the pc.
module rf_dump_ctrl #(
    parameter logic [31:0] HALT_PC    = 32'h0000_0048,
    parameter int          MAX_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    output logic [4:0]  reg_sel,
    input  logic [31:0] reg_data,
    output logic        cpu_stall,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic        done
);

    localparam logic [31:0] MAX_C   = 32'(MAX_CYCLES);
    localparam logic [5:0]  LAST_RF = 6'd33;

    typedef enum logic [1:0] {S_RUN, S_LOAD, S_SEND, S_DONE} state_t;

    state_t      state, state_d;
    logic [31:0] cyc_cnt;
    logic [5:0]  word_idx;
    logic        timeout;
    logic [31:0] cap_pc, cap_instr;
    logic [31:0] out_data_q, word_d;
    logic        out_last_q, last_d;
    logic        hit_pc, hit_budget;

    assign hit_pc     = (pc == HALT_PC);
    assign hit_budget = (cyc_cnt == MAX_C);

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_RUN;
        else       state <= state_d;
    end

    // Next state, register-file read select and the word to load into out_data
    always_comb begin
        state_d = state;
        reg_sel = 5'd0;
        word_d  = 32'd0;
        last_d  = 1'b0;
        case (state)
            S_RUN: begin
                if (hit_pc || hit_budget) state_d = S_LOAD;
            end
            S_LOAD: begin
                state_d = S_SEND;
                if (timeout) begin
                    word_d = (word_idx == 6'd0) ? {16'hDEAD, cyc_cnt[15:0]} : cap_pc;
                    last_d = (word_idx == 6'd1);
                end else begin
                    last_d = (word_idx == LAST_RF);
                    if (word_idx == 6'd0)      word_d = cap_pc;
                    else if (word_idx == 6'd1) word_d = cap_instr;
                    else begin
                        // rf words start at frame index 2; rf[0] reads as zero
                        reg_sel = 5'(word_idx - 6'd2);
                        word_d  = (word_idx == 6'd2) ? 32'd0 : reg_data;
                    end
                end
            end
            S_SEND: begin
                if (out_ready) state_d = out_last_q ? S_DONE : S_LOAD;
            end
            default: state_d = S_DONE;
        endcase
    end

    // Cycle budget counter, trigger capture, word index and output word registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cyc_cnt    <= 32'd0;
            word_idx   <= 6'd0;
            timeout    <= 1'b0;
            cap_pc     <= 32'd0;
            cap_instr  <= 32'd0;
            out_data_q <= 32'd0;
            out_last_q <= 1'b0;
        end else begin
            case (state)
                S_RUN: begin
                    if (!hit_budget) cyc_cnt <= cyc_cnt + 32'd1;
                    if (hit_pc || hit_budget) begin
                        cap_pc    <= pc;
                        cap_instr <= instr;
                        // a pc match on the budget edge still yields a normal frame
                        timeout   <= !hit_pc;
                        word_idx  <= 6'd0;
                    end
                end
                S_LOAD: begin
                    out_data_q <= word_d;
                    out_last_q <= last_d;
                end
                S_SEND: begin
                    if (out_ready && !out_last_q) word_idx <= word_idx + 6'd1;
                end
                default: ;
            endcase
        end
    end

    assign cpu_stall = (state != S_RUN);
    assign out_valid = (state == S_SEND);
    assign out_data  = out_data_q;
    assign out_last  = out_last_q && (state == S_SEND);
    assign done      = (state == S_DONE);

endmodule

// File: tb/tb_rf_dump_ctrl.sv
// Scoreboard bench for rf_dump_ctrl: each frame's expected words are worked
// out from the pc trajectory and pushed into a queue up front; a negedge
// monitor pops and compares on every accepted word and checks hold stability.
module tb_rf_dump_ctrl;

    localparam logic [31:0] HALT = 32'h0000_0048;
    localparam int          MAXC = 1000;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] pc = 32'd0, instr = 32'd0, reg_data;
    logic [4:0]  reg_sel;
    logic        cpu_stall, out_valid, out_ready = 1'b0, out_last, done;
    logic [31:0] out_data;
    logic [31:0] rf_mem [32];

    typedef struct packed { logic [31:0] d; logic l; } exp_t;
    exp_t exp_q[$];

    int n_tests = 0, n_fail = 0, n_acc = 0;
    logic        hold = 1'b0, held_l = 1'b0;
    logic [31:0] held_d = 32'd0;

    rf_dump_ctrl #(.HALT_PC(HALT), .MAX_CYCLES(MAXC)) dut (
        .clk(clk), .rstn(rstn), .pc(pc), .instr(instr), .reg_sel(reg_sel),
        .reg_data(reg_data), .cpu_stall(cpu_stall), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_last(out_last), .done(done)
    );

    always #5 clk = ~clk;
    assign reg_data = rf_mem[reg_sel];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: handshake completes at the next rising edge, so values seen
    // at the falling edge are the ones that will be transferred.
    always @(negedge clk) begin
        if (!rstn || !out_valid) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                chk("hold_data", out_data, held_d);
                chk("hold_last", {31'd0, out_last}, {31'd0, held_l});
            end
            if (out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", out_data, 32'hxxxx_xxxx);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("word_data", out_data, e.d);
                    chk("word_last", {31'd0, out_last}, {31'd0, e.l});
                end
                n_acc++;
                hold = 1'b0;
            end else begin
                hold   = 1'b1;
                held_d = out_data;
                held_l = out_last;
            end
        end
    end

    task automatic chk_idle(input string name);
        chk({name, "_valid"}, {31'd0, out_valid}, 32'd0);
        chk({name, "_last"},  {31'd0, out_last},  32'd0);
        chk({name, "_stall"}, {31'd0, cpu_stall}, 32'd0);
        chk({name, "_done"},  {31'd0, done},      32'd0);
        chk({name, "_data"},  out_data,           32'd0);
        chk({name, "_sel"},   {27'd0, reg_sel},   32'd0);
    endtask

    // rfm: 0 random rf, 1 rf[k]=k*0x11, 2 as 1 with rf[0] read back as all ones.
    // mode: 0 ready always, 1 ready toggling, 2 ready random.
    // abort_at >= 0: pull reset while word abort_at+1 is being offered.
    task automatic run_frame(input logic [31:0] p0, input int mode, input int rfm,
                             input int abort_at);
        logic [31:0] key, pcn;
        int trig, stall_edge;
        bit is_to;
        rstn = 1'b0;
        out_ready = 1'b0;
        key = $urandom;
        pc = p0;
        instr = p0 ^ key;
        for (int k = 0; k < 32; k++)
            rf_mem[k] = (rfm == 0) ? $urandom : 32'(k) * 32'h11;
        if (rfm == 2) rf_mem[0] = 32'hFFFF_FFFF;
        #3;
        chk_idle("reset");
        exp_q.delete();
        n_acc = 0;

        // Reference: walk the pc trajectory; a pc match wins over the budget.
        trig = 0;
        is_to = 1'b0;
        pcn = p0;
        for (int n = 1; n <= MAXC + 1; n++) begin
            pcn = p0 + 32'(4 * (n - 1));
            if (pcn == HALT) begin trig = n; break; end
            if (n - 1 >= MAXC) begin trig = n; is_to = 1'b1; break; end
        end
        if (is_to) begin
            exp_q.push_back('{{16'hDEAD, 16'(MAXC)}, 1'b0});
            exp_q.push_back('{pcn, 1'b1});
        end else begin
            exp_q.push_back('{pcn, 1'b0});
            exp_q.push_back('{pcn ^ key, 1'b0});
            exp_q.push_back('{32'd0, 1'b0});
            for (int k = 1; k < 32; k++) exp_q.push_back('{rf_mem[k], k == 31});
        end

        @(negedge clk);
        rstn = 1'b1;
        out_ready = 1'b1;
        stall_edge = -1;
        for (int e = 1; e <= 3000; e++) begin
            @(posedge clk);
            #1;
            if (cpu_stall && stall_edge < 0) stall_edge = e;
            if (done) break;
            if (!cpu_stall) begin
                pc = pc + 32'd4;
                instr = pc ^ key;
            end
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = ~out_ready;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (abort_at >= 0 && n_acc == abort_at && out_valid) begin
                rstn = 1'b0;
                #1;
                chk_idle("abort");
                return;
            end
        end
        chk("done", {31'd0, done}, 32'd1);
        chk("done_valid", {31'd0, out_valid}, 32'd0);
        chk("stall_edge", 32'(stall_edge), 32'(trig));
        chk("queue_left", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        // pc hits HALT on cycle 18, ready held high
        run_frame(32'h0000_0004, 0, 1, -1);
        // same with toggling ready
        run_frame(32'h0000_0004, 1, 1, -1);
        // never matches: timeout frame
        run_frame(32'h0000_0100, 2, 0, -1);
        // match on the very edge the budget runs out
        run_frame(HALT - 32'd4000, 0, 0, -1);
        // rf[0] reads all ones but must dump as zero
        run_frame(32'h0000_0008, 2, 2, -1);
        // reset while the tenth word is on offer, then a fresh frame
        run_frame(32'h0000_0004, 0, 1, 9);
        run_frame(32'h0000_0004, 0, 1, -1);
        for (int i = 0; i < 4; i++)
            run_frame(HALT - 32'(4 * $urandom_range(0, 40)), $urandom_range(0, 2), 0, -1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
